// File: rtl/hi_xcorr_deserializer_if.sv
// Result stream from the correlator deserializer: one {I,Q,mag,carrier,amod} entry per beat.
// Valid/ready handshake; the producer holds the head stable while out_valid & ~out_ready.
interface hi_xcorr_deserializer_if;
  logic [7:0] out_i;
  logic [7:0] out_q;
  logic [8:0] out_mag;
  logic       out_carrier;
  logic [1:0] out_amod;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_i, out_q, out_mag, out_carrier, out_amod, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_i, out_q, out_mag, out_carrier, out_amod, out_valid,
    output out_ready
  );
endinterface

// File: rtl/hi_xcorr_deserializer.sv
// SSP correlator word deserializer with magnitude and carrier hysteresis; out_valid 2 cycles after the 16th bit.
// Results queue in a show-ahead FIFO; a word arriving while it is full is dropped and overflow sticks.
module hi_xcorr_deserializer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       ck_1356meg,
  input  logic       reset_n,
  input  logic       ssp_clk,
  input  logic       ssp_frame,
  input  logic       ssp_din,
  input  logic       snoop,
  input  logic [8:0] thresh_hi,
  input  logic [8:0] thresh_lo,
  output logic       overflow,
  output logic       frame_err,
  hi_xcorr_deserializer_if.master res
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] q;
    logic [8:0] mag;
    logic       carrier;
    logic [1:0] amod;
  } entry_t;

  function automatic logic [8:0] abs9(input logic [7:0] v);
    return v[7] ? (9'd256 - {1'b0, v}) : {1'b0, v};
  endfunction

  // {clk, frame, din} travel together so they stay cycle-aligned
  logic [2:0] sync_q [SYNC_STAGES];
  logic       clk_d;
  logic       s_clk, s_frame, s_din, sample;

  assign {s_clk, s_frame, s_din} = sync_q[SYNC_STAGES-1];
  assign sample = s_clk & ~clk_d;

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      clk_d <= 1'b0;
    end else begin
      sync_q[0] <= {ssp_clk, ssp_frame, ssp_din};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      clk_d <= s_clk;
    end
  end

  logic [15:0] sr;
  logic [4:0]  cnt;
  logic        word_done;

  // cnt==0 means "waiting for frame", cnt==16 means "word done, ignore bits until next frame"
  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      sr        <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
      word_done <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      word_done <= 1'b0;
      if (sample) begin
        if (s_frame) begin
          sr        <= {15'd0, s_din};
          cnt       <= 5'd1;
          frame_err <= (cnt != 5'd0) && (cnt != 5'd16);
        end else if ((cnt != 5'd0) && (cnt != 5'd16)) begin
          sr        <= {sr[14:0], s_din};
          cnt       <= cnt + 5'd1;
          word_done <= (cnt == 5'd15);
        end
      end
    end
  end

  logic [7:0] raw_i, raw_q, cor_i, cor_q;
  logic       s1_vld;
  logic [7:0] s1_i, s1_q;
  logic [8:0] s1_mag;
  logic [1:0] s1_amod;

  assign raw_i = sr[15:8];
  assign raw_q = sr[7:0];
  assign cor_i = snoop ? {raw_i[7:1], 1'b0} : raw_i;
  assign cor_q = snoop ? {raw_q[7:1], 1'b0} : raw_q;

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_i    <= '0;
      s1_q    <= '0;
      s1_mag  <= '0;
      s1_amod <= '0;
    end else begin
      s1_vld <= word_done;
      if (word_done) begin
        s1_i    <= cor_i;
        s1_q    <= cor_q;
        s1_mag  <= abs9(cor_i) + abs9(cor_q);
        s1_amod <= snoop ? {raw_i[0], raw_q[0]} : 2'b00;
      end
    end
  end

  logic          carrier, carrier_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          vld, full, push, pop;
  entry_t        mem [FIFO_DEPTH];
  entry_t        new_entry, head;

  always_comb begin
    carrier_nxt = carrier;
    if (s1_mag >= thresh_hi)     carrier_nxt = 1'b1;
    else if (s1_mag < thresh_lo) carrier_nxt = 1'b0;
  end

  assign new_entry = '{i: s1_i, q: s1_q, mag: s1_mag, carrier: carrier_nxt, amod: s1_amod};
  assign vld  = (count != '0);
  assign full = (count == FULL_CNT);
  assign pop  = vld & res.out_ready;
  assign push = s1_vld & (~full | pop);

  // carrier advances on every completed word, even one that is dropped
  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      carrier  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (s1_vld) carrier <= carrier_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (s1_vld && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  assign head            = mem[rd_ptr];
  assign res.out_valid   = vld;
  assign res.out_i       = vld ? head.i       : '0;
  assign res.out_q       = vld ? head.q       : '0;
  assign res.out_mag     = vld ? head.mag     : '0;
  assign res.out_carrier = vld ? head.carrier : 1'b0;
  assign res.out_amod    = vld ? head.amod    : '0;

endmodule

// File: doc/hi_xcorr_deserializer.md
HI_XCORR_DESERIALIZER -- requirements
Module: hi_xcorr_deserializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered result entries (power of two, min 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each SSP input.
REQ-003 SHALL have port ck_1356meg  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ssp_clk  input  1  serial bit clock from correlator, asynchronous data (not a clock).
REQ-006 SHALL have port ssp_frame  input  1  word-start marker from correlator.
REQ-007 SHALL have port ssp_din  input  1  serial data, MSB first.
REQ-008 SHALL have port snoop  input  1  LSBs of I/Q carry AM hysteresis bits, not correlation.
REQ-009 SHALL have port thresh_hi  input  9  carrier-present set threshold.
REQ-010 SHALL have port thresh_lo  input  9  carrier-present clear threshold.
REQ-011 SHALL have port out_i  output  8  signed I correlation.
REQ-012 SHALL have port out_q  output  8  signed Q correlation.
REQ-013 SHALL have port out_mag  output  9  |I|+|Q|.
REQ-014 SHALL have port out_carrier  output  1  hysteresis carrier-present decision.
REQ-015 SHALL have port out_amod  output  2  {I LSB, Q LSB} when snoop, else 0.
REQ-016 SHALL have port out_valid  output  1  FIFO head valid.
REQ-017 SHALL have port out_ready  input  1  consumer accepts head.
REQ-018 SHALL have port overflow  output  1  sticky: word dropped because FIFO full.
REQ-019 SHALL have port frame_err  output  1  one-cycle pulse: frame seen mid-word.

Function
REQ-020 ssp_clk/ssp_frame/ssp_din SHALL each pass SYNC_STAGES flops; sampling SHALL occur on rising edge of synchronized ssp_clk (one extra flop for edge detect).
REQ-021 At sample edge with synced ssp_frame=1: shift reg <= din, bit count <= 1; if prior count was 1..15, pulse frame_err next cycle.
REQ-022 At sample edge with frame=0 and count 1..15: shift in din at LSB, count+1; count 0 or 16: ignore bit, count unchanged.
REQ-023 Count reaching 16 SHALL mark word complete: bits[15:8]=I, bits[7:0]=Q.
REQ-024 Stage 1 (cycle after completion): register I, Q; when snoop, out_amod={I[0],Q[0]} and I[0],Q[0] forced to 0 before magnitude; else amod=0.
REQ-025 mag = abs(I)+abs(Q), 9-bit unsigned, abs(-128)=128; max 256, no saturation needed.
REQ-026 Carrier state: set when mag >= thresh_hi; clear when mag < thresh_lo; else hold; updated once per word, value stored with that word.
REQ-027 Stage 2: entry {I,Q,mag,carrier,amod} pushed to show-ahead FIFO; out_valid high the cycle after push into empty FIFO (2 cycles after 16th-bit capture).
REQ-028 Pop when out_valid & out_ready; outputs SHALL hold stable while out_valid & ~out_ready.
REQ-029 Push when full without simultaneous pop: entry dropped, overflow set, cleared only by reset.
REQ-030 Push and pop same cycle when full: both accepted, no overflow.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy 0..FIFO_DEPTH exact.

Reset
REQ-032 reset_n low SHALL asynchronously clear synchronizers, shift reg, bit count, carrier state, FIFO pointers; out_valid=0, overflow=0, frame_err=0, out_i/q/mag/amod/carrier=0.
REQ-033 Reset mid-word SHALL discard partial word; first word after release requires a fresh frame.

Verification
REQ-034 Frame then 16 bits 0x7F80 (I=127,Q=-128), snoop=0, thresh_hi=200, thresh_lo=100 -> out_i=127, out_q=-128, mag=255, carrier=1, out_valid 2 cycles after 16th capture.
REQ-035 snoop=1, word 0x0301 -> out_i=2, out_q=0, amod=2'b11, mag=2.
REQ-036 Words mag 250,150,50,150 -> carrier 1,1,0,0.
REQ-037 out_ready=0, 5 words -> 4 buffered, overflow=1; then drain -> 4 entries in order, out_valid drops.
REQ-038 Frame after 9 bits -> frame_err one-cycle pulse, new word captured correctly; 20 bits after frame -> exactly one push.
REQ-039 reset_n low after 8 bits -> all outputs 0; 8 more bits without frame -> no push.
